// File: rtl/avalon_pio_irq_if.sv
// avalon_pio_irq_if: Avalon-MM slave bus for the PIO block (zero-wait-state, read latency 0).
interface avalon_pio_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_irq.sv
// avalon_pio_irq: Avalon-MM PIO with output register, synchronised inputs and edge-capture interrupt.
module avalon_pio_irq #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_pio_irq_if.slave       bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);
  localparam int DW = DATA_WIDTH;
  logic [DW-1:0] out_q, out_d, mask_q, mask_d, cap_q, cap_d;
  logic [DW-1:0] sync1_q, sync2_q, prev_q, det, wd, rdv;
  logic [1:0]    mode_q, mode_d, arm_q;
  logic          irq_q, wr, unused_wd;
  assign wr = bus.chipselect & ~bus.write_n;
  assign wd = bus.writedata[DW-1:0];
  assign unused_wd = ^bus.writedata;
  always_comb begin
    out_d = !wr ? out_q
          : (bus.address == 3'd0 || bus.address == 3'd1) ? wd
          : bus.address == 3'd4 ? out_q | wd
          : bus.address == 3'd5 ? out_q & ~wd
          : out_q;
    mask_d = (wr && bus.address == 3'd2) ? wd : mask_q;
    mode_d = (wr && bus.address == 3'd6) ? bus.writedata[1:0] : mode_q;
    // Detection stays off until the synchroniser and prev have filled after reset.
    det = arm_q != 2'd3 ? '0
        : mode_q == 2'd0 ? sync2_q & ~prev_q
        : mode_q == 2'd1 ? ~sync2_q & prev_q
        : mode_q == 2'd2 ? sync2_q ^ prev_q
        : '0;
    cap_d = (cap_q & ~((wr && bus.address == 3'd3) ? wd : '0)) | det;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= RESET_VALUE;
      mask_q  <= '0;
      cap_q   <= '0;
      mode_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      mode_q  <= mode_d;
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
      irq_q   <= |(cap_q & mask_q);
    end
  end
  assign rdv = bus.address == 3'd0 ? sync2_q
             : bus.address == 3'd1 ? out_q
             : bus.address == 3'd2 ? mask_q
             : bus.address == 3'd3 ? cap_q
             : '0;
  assign bus.readdata = bus.address == 3'd6 ? {30'd0, mode_q} : 32'(rdv);
  assign out_port = out_q;
  assign irq = irq_q;
endmodule
